// File: rtl/add_sub_predicates.sv
// rtl/add_sub_predicates.sv - two-stage pipelined adder/subtractor with carry-in vector and compare predicates
module add_sub_predicates #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_A,
    input  logic [WORD_WIDTH-1:0] in_B,
    input  logic                  in_sub,
    input  logic                  in_carry_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_sum,
    output logic                  out_carry_out,
    output logic [WORD_WIDTH-1:0] out_carryin,
    output logic                  out_overflow,
    output logic                  out_negative,
    output logic                  out_eq,
    output logic                  out_lt_u,
    output logic                  out_lt_s
);
    localparam int MSB = WORD_WIDTH - 1;

    logic                  w_adv1, w_adv2;
    logic [WORD_WIDTH-1:0] w_b_eff;
    logic [WORD_WIDTH:0]   w_sum_ext;
    logic [WORD_WIDTH-1:0] w_carryin;
    logic                  w_overflow;

    logic                  r_v1, r_v2;
    logic [WORD_WIDTH-1:0] r_a1, r_b1, r_sum1;
    logic                  r_cin1, r_cout1;

    logic [WORD_WIDTH-1:0] r_sum2, r_carryin2;
    logic                  r_cout2, r_ovf2, r_neg2, r_eq2, r_ltu2, r_lts2;

    // Ready chains combinationally from out_ready; there is no skid buffer.
    assign w_adv2   = ~r_v2 | out_ready;
    assign w_adv1   = ~r_v1 | w_adv2;
    assign in_ready = w_adv1;

    assign w_b_eff   = in_sub ? ~in_B : in_B;
    assign w_sum_ext = {1'b0, in_A} + {1'b0, w_b_eff} + {{WORD_WIDTH{1'b0}}, in_carry_in};

    assign w_carryin  = r_a1 ^ r_b1 ^ r_sum1;
    assign w_overflow = w_carryin[MSB] ^ r_cout1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v1   <= 1'b0;
            r_a1   <= '0;
            r_b1   <= '0;
            r_sum1 <= '0;
            r_cin1 <= 1'b0;
            r_cout1 <= 1'b0;
        end else if (w_adv1) begin
            r_v1    <= in_valid;
            r_a1    <= in_A;
            r_b1    <= w_b_eff;
            r_cin1  <= in_carry_in;
            r_sum1  <= w_sum_ext[MSB:0];
            r_cout1 <= w_sum_ext[WORD_WIDTH];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v2       <= 1'b0;
            r_sum2     <= '0;
            r_carryin2 <= '0;
            r_cout2    <= 1'b0;
            r_ovf2     <= 1'b0;
            r_neg2     <= 1'b0;
            r_eq2      <= 1'b0;
            r_ltu2     <= 1'b0;
            r_lts2     <= 1'b0;
        end else if (w_adv2) begin
            r_v2       <= r_v1;
            r_sum2     <= r_sum1;
            r_carryin2 <= w_carryin;
            r_cout2    <= r_cout1;
            r_ovf2     <= w_overflow;
            r_neg2     <= r_sum1[MSB];
            r_eq2      <= (r_sum1 == '0);
            r_ltu2     <= ~r_cout1;
            r_lts2     <= r_sum1[MSB] ^ w_overflow;
        end
    end

    assign out_valid     = r_v2;
    assign out_sum       = r_sum2;
    assign out_carry_out = r_cout2;
    assign out_carryin   = r_carryin2;
    assign out_overflow  = r_ovf2;
    assign out_negative  = r_neg2;
    assign out_eq        = r_eq2;
    assign out_lt_u      = r_ltu2;
    assign out_lt_s      = r_lts2;

    // Stage-1 carry-in is implied by bit 0 of the carry-in vector; kept for observability.
    logic w_unused;
    assign w_unused = r_cin1;
endmodule

// File: tb/tb_add_sub_predicates.sv
// tb/tb_add_sub_predicates.sv - directed vector and backpressure bench for add_sub_predicates
module tb_add_sub_predicates;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         in_valid, in_ready, in_sub, in_carry_in;
    logic [W-1:0] in_A, in_B;
    logic         out_valid, out_ready;
    logic [W-1:0] out_sum, out_carryin;
    logic         out_carry_out, out_overflow, out_negative, out_eq, out_lt_u, out_lt_s;

    always #5 clock = ~clock;

    add_sub_predicates #(.WORD_WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_sub(in_sub), .in_carry_in(in_carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry_out(out_carry_out), .out_carryin(out_carryin),
        .out_overflow(out_overflow), .out_negative(out_negative), .out_eq(out_eq),
        .out_lt_u(out_lt_u), .out_lt_s(out_lt_s)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic [W-1:0] cvec;
        logic         ovf;
        logic         neg;
        logic         eq;
        logic         ltu;
        logic         lts;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        res_t         exp;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vq[$];
    res_t exp_q[$];

    // Bit-serial ripple reference, independent of the xor-recovery used in the design.
    function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic sub, logic cin);
        res_t r;
        logic c, bb;
        c = cin;
        for (int i = 0; i < W; i++) begin
            bb         = sub ? ~b[i] : b[i];
            r.cvec[i]  = c;
            r.sum[i]   = a[i] ^ bb ^ c;
            c          = (a[i] & bb) | (a[i] & c) | (bb & c);
        end
        r.cout = c;
        r.ovf  = r.cvec[W-1] ^ c;
        r.neg  = r.sum[W-1];
        r.eq   = (r.sum == '0);
        r.ltu  = ~c;
        r.lts  = r.sum[W-1] ^ r.ovf;
        return r;
    endfunction

    function automatic res_t got();
        res_t r;
        r.sum = out_sum;     r.cout = out_carry_out; r.cvec = out_carryin;
        r.ovf = out_overflow; r.neg = out_negative;  r.eq = out_eq;
        r.ltu = out_lt_u;    r.lts = out_lt_s;
        return r;
    endfunction

    task automatic check_res(string name, res_t act, res_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got sum=%h cout=%b cvec=%h ovf=%b neg=%b eq=%b ltu=%b lts=%b, expected sum=%h cout=%b cvec=%h ovf=%b neg=%b eq=%b ltu=%b lts=%b",
                     name, act.sum, act.cout, act.cvec, act.ovf, act.neg, act.eq, act.ltu, act.lts,
                     exp.sum, exp.cout, exp.cvec, exp.ovf, exp.neg, exp.eq, exp.ltu, exp.lts);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(logic [W-1:0] a, logic [W-1:0] b, logic sub, logic cin,
                           logic [W-1:0] sum, logic cout, logic [W-1:0] cvec,
                           logic ovf, logic neg, logic eq, logic ltu, logic lts);
        vec_t v;
        v.a = a; v.b = b; v.sub = sub; v.cin = cin;
        v.exp.sum = sum; v.exp.cout = cout; v.exp.cvec = cvec; v.exp.ovf = ovf;
        v.exp.neg = neg; v.exp.eq = eq; v.exp.ltu = ltu; v.exp.lts = lts;
        vq.push_back(v);
    endtask

    // Offer one op with out_ready high, then wait for its result and check latency and payload.
    task automatic apply(string name, logic [W-1:0] a, logic [W-1:0] b, logic sub, logic cin, res_t exp);
        int t;
        @(negedge clock);
        in_A = a; in_B = b; in_sub = sub; in_carry_in = cin;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        t = 0;
        while (!in_ready && t < 8) begin
            @(negedge clock); #1; t++;
        end
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 8) begin
            @(negedge clock); t++;
        end
        check_int({name, "_latency"}, t, 1);
        check_res(name, got(), exp);
    endtask

    initial begin
        logic [W-1:0] ba[6], bb[6];
        logic         bs[6], bc[6];
        int           k, popped;
        logic         stalled, acc, xfer;
        res_t         snap;

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_A = '0; in_B = '0; in_sub = 1'b0; in_carry_in = 1'b0;

        add_vec(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        add_vec(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        add_vec(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec(8'h3C, 8'h3C, 1'b1, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 8'h60, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add_vec(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add_vec(8'h7F, 8'hFF, 1'b1, 1'b1, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        #12;
        check_int("reset_out_valid", int'(out_valid), 0);
        check_res("reset_payload", got(), '0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++)
            apply($sformatf("vec%0d", i), vq[i].a, vq[i].b, vq[i].sub, vq[i].cin, vq[i].exp);

        // Fill both stages under backpressure, then reset asynchronously mid-cycle.
        @(negedge clock);
        out_ready = 1'b0; in_valid = 1'b1;
        in_A = 8'h11; in_B = 8'h22; in_sub = 1'b0; in_carry_in = 1'b0;
        @(negedge clock);
        in_A = 8'h33; in_B = 8'h44;
        @(negedge clock);
        in_valid = 1'b0;
        #2;
        check_int("prereset_full_valid", int'(out_valid), 1);
        check_int("prereset_full_ready", int'(in_ready), 0);
        reset_n = 1'b0;
        #1;
        check_int("async_reset_valid", int'(out_valid), 0);
        check_res("async_reset_payload", got(), '0);
        @(negedge clock);
        reset_n = 1'b1;
        apply("post_reset_first", 8'h5A, 8'h23, 1'b1, 1'b1, model(8'h5A, 8'h23, 1'b1, 1'b1));

        for (int i = 0; i < 6; i++) begin
            ba[i] = 8'($urandom); bb[i] = 8'($urandom);
            bs[i] = 1'($urandom_range(0, 1)); bc[i] = 1'($urandom_range(0, 1));
        end
        k = 0; popped = 0; stalled = 1'b0; snap = '0;
        for (int cyc = 0; cyc < 200 && popped < 6; cyc++) begin
            @(negedge clock);
            if (cyc < 2)      out_ready = 1'b0;
            else if (cyc < 4) out_ready = 1'b0;
            else if (cyc < 8) out_ready = 1'b1;
            else              out_ready = 1'($urandom_range(0, 1));
            if (k < 6) begin
                in_valid = 1'b1; in_A = ba[k]; in_B = bb[k]; in_sub = bs[k]; in_carry_in = bc[k];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 0) check_int("bp_ready_empty", int'(in_ready), 1);
            if (cyc == 2 || cyc == 3) check_int("bp_ready_full", int'(in_ready), 0);
            if (cyc == 4) check_int("bp_ready_release", int'(in_ready), 1);
            if (stalled) begin
                check_int("bp_hold_valid", int'(out_valid), 1);
                check_res("bp_hold_payload", got(), snap);
            end
            stalled = out_valid && !out_ready;
            snap    = got();
            acc     = in_valid && in_ready;
            xfer    = out_valid && out_ready;
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    check_int("bp_spurious_output", 1, 0);
                end else begin
                    check_res($sformatf("bp_result%0d", popped), got(), exp_q.pop_front());
                end
                popped++;
            end
            if (acc) begin
                exp_q.push_back(model(ba[k], bb[k], bs[k], bc[k]));
                k++;
            end
        end
        check_int("bp_accepted", k, 6);
        check_int("bp_delivered", popped, 6);
        check_int("bp_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
